uart_fifo_drain: RTL and testbench
==================================

# uart_fifo_drain

Downstream consumer of the SRAM-backed FIFO interface. Watches the FIFO's `nempty` flag, fetches one byte at a time with an active-low `fiford` strobe, and serializes each byte on an 8N1 UART transmit line (8E1 with parity compiled in). Sits between the FIFO interface's `out_data`/`nempty`/`fiford` pins and the board-level TX pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clk cycles per UART bit; legal range 4..65535.
- `RD_LOW`, default 3: cycles `fiford` is held low per fetch; legal minimum 3.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `nempty`  in  1  FIFO not-empty flag, synchronous to `clk`.
- `fifo_data`  in  8  FIFO `out_data`; valid while the FIFO is in its read states.
- `tx_en`  in  1  1 = new fetches allowed; 0 = finish the current frame, then hold in IDLE.
- `fiford`  out  1  FIFO read strobe, active-low, registered.
- `txd`  out  1  UART serial output, registered, idles high.
- `busy`  out  1  high whenever state is not IDLE.
- `sent_cnt`  out  16  count of frames completed; wraps 0xFFFF -> 0.

## Operation
- States: IDLE, RD_REQ, START, DATA, PARITY (only with macro), STOP.
- IDLE: if `tx_en`=1 and `nempty`=1, go to RD_REQ and drive `fiford`<=0. Otherwise stay.
- RD_REQ: hold `fiford` low for `RD_LOW` cycles. On the last cycle: `shreg`<=`fifo_data`, `fiford`<=1, `txd`<=0, go to START. `tx_en` is ignored once RD_REQ is entered.
- START: `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: 8 bits, LSB first, each lasting `CLKS_PER_BIT` cycles. A 3-bit index counts 0..7, then the FSM moves to PARITY or STOP.
- PARITY: even parity of `shreg` for one bit time.
- STOP: `txd`=1 for one bit time. Then `sent_cnt`+=1 and go to IDLE.
- Baud counter: 16 bits, cleared on every bit-state entry, with a terminal count of `CLKS_PER_BIT`-1. There is no free-running tick.
- `nempty` is sampled only in IDLE. The FIFO's flag lag is always covered because the frame is far longer than the FIFO's two-cycle read-release sequence.
- Reset asserted mid-frame: outputs go immediately to their reset values. The byte in flight is lost and is not re-read.

## Timing
- Reset values: `fiford`=1, `txd`=1, `busy`=0, `sent_cnt`=0, state IDLE.
- Edge E0 (IDLE, `nempty`=1, `tx_en`=1): `fiford` goes low after E0.
- Edges E1..E`RD_LOW`: FIFO steps idle -> read_ready (E1) -> read (E2). Data is captured at E`RD_LOW`, when `fiford` returns high and `txd` falls.
- `fiford` is low for exactly `RD_LOW` cycles.
- Start bit begins the cycle after E`RD_LOW`.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- Back-to-back frames: the next `fiford` fall is 1 cycle after the STOP bit ends, so IDLE lasts 1 cycle.
- `busy` rises with `fiford` falling. It falls on the cycle `sent_cnt` increments.

## Configuration
- `UART_PARITY_EN` defined: PARITY state is present and frames are 11 bits with an even parity bit.
- `UART_PARITY_EN` undefined: PARITY state and its logic are absent, and frames are 10 bits (8N1).

## Structure
- Shared package `uart_pkg`:
  - state encoding constants (IDLE, RD_REQ, START, DATA, PARITY, STOP);
  - data width 8;
  - default `CLKS_PER_BIT`.
- Sub-module `uart_bit_timer`: loadable 16-bit baud counter with `clr` input and `done` output, reused by the future receiver.

## Test plan
- Reset: hold `rst`=0 with `nempty`=1 -> `fiford`=1, `txd`=1, `busy`=0, `sent_cnt`=0, and no fetch until release.
- Single byte 0xA5, `CLKS_PER_BIT`=16:
  - `fiford` low exactly 3 cycles.
  - `txd` = 0,1,0,1,0,0,1,0,1,1, each level 16 cycles.
  - Then `sent_cnt`=1 and `busy`=0.
- Parity build, byte 0x07 -> parity bit 1; byte 0xA5 -> parity bit 0; frame 176 cycles.
- Three bytes queued (0x11, 0x22, 0x33), `nempty` held high:
  - three frames, each 1 IDLE cycle apart;
  - `sent_cnt`=3;
  - each `fiford` pulse is 3 cycles.
- `tx_en` dropped mid-frame on 0x55 -> the frame completes intact, no further `fiford` pulse while `tx_en`=0, and fetching resumes 1 cycle after `tx_en`=1.
- `rst` pulsed during DATA bit 4 -> `txd`=1 and `fiford`=1 immediately, `sent_cnt`=0, and the next frame starts cleanly from IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and default bit timing.
// Used by uart_fifo_drain (and its optional UART_PARITY_EN build) and uart_bit_timer.
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int TIMER_W          = 16;
    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_e;

    // Even parity bit: makes the total count of ones in data+parity even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Clearable 16-bit baud counter; done flags the terminal count of the current bit.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [TIMER_W-1:0] tc,
    output logic               done
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : cnt_q + TIMER_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == tc);

endmodule

// File: rtl/uart_fifo_drain.sv
// Fetches bytes from the FIFO read port and sends each as one UART frame (8N1).
// Define UART_PARITY_EN to insert an even parity bit (8E1).
module uart_fifo_drain
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned RD_LOW       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nempty,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              tx_en,
    output logic              fiford,
    output logic              txd,
    output logic              busy,
    output logic [15:0]       sent_cnt
);

    localparam logic [TIMER_W-1:0] BIT_TC = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [15:0]        RD_TC  = 16'(RD_LOW - 1);

    uart_state_e       state_q, state_d;
    logic [15:0]       rd_cnt_q, rd_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              fiford_q, fiford_d;
    logic              txd_q, txd_d;
    logic [15:0]       sent_cnt_q, sent_cnt_d;
    logic              timer_clr;
    logic              bit_done;

    uart_bit_timer u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .tc   (BIT_TC),
        .done (bit_done)
    );

    // Timer is held clear outside bit states so each bit state starts at zero.
    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        fiford_d   = fiford_q;
        txd_d      = txd_q;
        sent_cnt_d = sent_cnt_q;
        timer_clr  = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (tx_en && nempty) begin
                    state_d  = ST_RD_REQ;
                    fiford_d = 1'b0;
                    rd_cnt_d = '0;
                end
            end
            ST_RD_REQ: begin
                if (rd_cnt_q == RD_TC) begin
                    shreg_d  = fifo_data;
                    fiford_d = 1'b1;
                    txd_d    = 1'b0;
                    state_d  = ST_START;
                end else begin
                    rd_cnt_d = rd_cnt_q + 16'd1;
                end
            end
            ST_START: begin
                timer_clr = bit_done;
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = shreg_q[0];
                end
            end
            ST_DATA: begin
                timer_clr = bit_done;
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = ST_PARITY;
                        txd_d   = even_parity(shreg_q);
`else
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shreg_q[bit_idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                timer_clr = bit_done;
                if (bit_done) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                timer_clr = bit_done;
                if (bit_done) begin
                    state_d    = ST_IDLE;
                    sent_cnt_d = sent_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                fiford_d = 1'b1;
                txd_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rd_cnt_q   <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            fiford_q   <= 1'b1;
            txd_q      <= 1'b1;
            sent_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            fiford_q   <= fiford_d;
            txd_q      <= txd_d;
            sent_cnt_q <= sent_cnt_d;
        end
    end

    assign fiford   = fiford_q;
    assign txd      = txd_q;
    assign busy     = (state_q != ST_IDLE);
    assign sent_cnt = sent_cnt_q;

endmodule

// File: tb/tb_uart_fifo_drain.sv
// Directed + random bench for uart_fifo_drain with a queue-based FIFO and frame model.
module tb_uart_fifo_drain;

    localparam int CPB = 16;
    localparam int RDL = 3;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        nempty = 1'b0;
    logic        tx_en = 1'b0;
    logic [7:0]  fifo_data = 8'h00;
    logic        fiford;
    logic        txd;
    logic        busy;
    logic [15:0] sent_cnt;

    int compared = 0;
    int mismatched = 0;
    int exp_sent = 0;
    byte unsigned fifo_q[$];

    always #5 clk = ~clk;

    uart_fifo_drain #(
        .CLKS_PER_BIT (CPB),
        .RD_LOW       (RDL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .nempty    (nempty),
        .fifo_data (fifo_data),
        .tx_en     (tx_en),
        .fiford    (fiford),
        .txd       (txd),
        .busy      (busy),
        .sent_cnt  (sent_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_refresh();
        nempty    = (fifo_q.size() != 0);
        fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push(input byte unsigned b);
        fifo_q.push_back(b);
        fifo_refresh();
    endtask

    // Expected line levels of one frame, index 0 = start bit.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f = 11'h7FF;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i + 1] = b[i];
`ifdef UART_PARITY_EN
        f[9] = 1'($countones(b) % 2);
`endif
        return f;
    endfunction

    // Waits for a fetch, checks the strobe width and every line cycle of the frame.
    task automatic run_frame(input string tag, input int exp_wait, input int drop_at);
        logic [7:0]  b;
        logic [10:0] fb;
        int n;
        int low;
        n = 0;
        while (fiford !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_fetch"}, 32'(fiford), 32'd0);
        if (fiford !== 1'b0) return;
        if (exp_wait >= 0) check({tag, "_wait"}, 32'(n), 32'(exp_wait));
        check({tag, "_busy_rd"}, 32'(busy), 32'd1);
        b  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        fb = frame_bits(b);
        low = 0;
        while (fiford === 1'b0 && low < 20) begin
            @(negedge clk);
            low++;
        end
        check({tag, "_rd_low"}, 32'(low), 32'(RDL));
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_refresh();
        for (int c = 0; c < NBITS * CPB; c++) begin
            if (c == drop_at) tx_en = 1'b0;
            check({tag, "_txd"}, 32'(txd), 32'(fb[4'(c / CPB)]));
            if (c % CPB == 0) check({tag, "_busy"}, 32'(busy), 32'd1);
            @(negedge clk);
        end
        exp_sent = (exp_sent + 1) & 16'hFFFF;
        check({tag, "_sent"}, 32'(sent_cnt), 32'(exp_sent));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_txd_idle"}, 32'(txd), 32'd1);
        $display("frame %s: byte %02h wait %0d fiford_low %0d sent_cnt %0d", tag, b, n, low, sent_cnt);
    endtask

    initial begin
        logic [10:0] fb;
        int n;

        // Reset held with data available: no fetch, reset outputs.
        rst   = 1'b0;
        tx_en = 1'b1;
        push(8'hA5);
        repeat (6) begin
            @(negedge clk);
            check("rst_fiford", 32'(fiford), 32'd1);
        end
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sent", 32'(sent_cnt), 32'd0);
        rst = 1'b1;
        run_frame("a5", 1, -1);

        // Three bytes queued back to back.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        run_frame("b11", 1, -1);
        run_frame("b22", 1, -1);
        run_frame("b33", 1, -1);

        // Random bytes.
        for (int i = 0; i < 4; i++) begin
            push(8'($urandom_range(0, 255)));
            run_frame("rand", 1, -1);
        end

        // Empty FIFO: stays idle.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("empty_fiford", 32'(fiford), 32'd1);
        end

        // tx_en dropped mid-frame: frame completes, no new fetch until re-enabled.
        push(8'h55);
        push(8'($urandom_range(0, 255)));
        run_frame("txen55", 1, 5 * CPB);
        for (int i = 0; i < 30; i++) begin
            check("txen_off_fiford", 32'(fiford), 32'd1);
            check("txen_off_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        tx_en = 1'b1;
        run_frame("resume", 1, -1);

        // Reset pulsed during data bit 4.
        push(8'($urandom_range(0, 255)));
        fb = frame_bits(fifo_q[0]);
        n = 0;
        while (fiford !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (fiford === 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        void'(fifo_q.pop_front());
        fifo_refresh();
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        check("mid_bit4_txd", 32'(txd), 32'(fb[5]));
        #1 rst = 1'b0;
        #1;
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_fiford", 32'(fiford), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sent", 32'(sent_cnt), 32'd0);
        exp_sent = 0;
        $display("reset mid-frame: txd %0d fiford %0d sent_cnt %0d", txd, fiford, sent_cnt);
        @(negedge clk);
        push(8'h3C);
        @(negedge clk);
        rst = 1'b1;
        run_frame("post_rst", 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
